// File: rtl/scm_access_ctrl.sv
// -----------------------------------------------------------------------------
// scm_access_ctrl
// Front-end controller for a latch-based 1W / N-read register file. It sits
// between a 128b wide writer, a 64b narrow writer and a 128b reader.
//   - Wide writes are split into two narrow writes: low half, then high half.
//   - The single write port is shared round-robin between the two writers.
//   - A read is held off while its wide index has write data that the latch
//     array has not captured yet.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   wide_req_i/addr_i/wdata_i   wide write request, wide index, 128b data
//   wide_gnt_o                  wide request accepted this cycle
//   nar_req_i/addr_i/wdata_i    narrow write request, narrow index, 64b data
//   nar_gnt_o                   narrow request accepted this cycle
//   rd_req_i/addr_i, rd_gnt_o   read request, wide index, read accepted
//   rd_rvalid_o, rd_rdata_o     read data valid one cycle after grant, data
//   rf_we_o/waddr_o/wdata_o     register file write port
//   rf_re_o/raddr_o, rf_rdata_i register file read port
// -----------------------------------------------------------------------------
module scm_access_ctrl #(
    parameter int WADDR_WIDTH = 5,
    parameter int WDATA_WIDTH = 64,
    parameter int RADDR_WIDTH = WADDR_WIDTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wide_req_i,
    input  logic [RADDR_WIDTH-1:0]   wide_addr_i,
    input  logic [2*WDATA_WIDTH-1:0] wide_wdata_i,
    output logic                     wide_gnt_o,
    input  logic                     nar_req_i,
    input  logic [WADDR_WIDTH-1:0]   nar_addr_i,
    input  logic [WDATA_WIDTH-1:0]   nar_wdata_i,
    output logic                     nar_gnt_o,
    input  logic                     rd_req_i,
    input  logic [RADDR_WIDTH-1:0]   rd_addr_i,
    output logic                     rd_gnt_o,
    output logic                     rd_rvalid_o,
    output logic [2*WDATA_WIDTH-1:0] rd_rdata_o,
    output logic                     rf_we_o,
    output logic [WADDR_WIDTH-1:0]   rf_waddr_o,
    output logic [WDATA_WIDTH-1:0]   rf_wdata_o,
    output logic                     rf_re_o,
    output logic [RADDR_WIDTH-1:0]   rf_raddr_o,
    input  logic [2*WDATA_WIDTH-1:0] rf_rdata_i
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WIDE_HI = 1'b1
    } state_t;

    state_t                   r_state;
    logic                     r_rr_wide;   // 1: wide wins the next contention
    logic [RADDR_WIDTH-1:0]   r_hi_addr;
    logic [WDATA_WIDTH-1:0]   r_hi_data;
    logic                     r_prev_vld;  // a write was issued last cycle
    logic [RADDR_WIDTH-1:0]   r_prev_idx;  // its wide index
    logic                     r_rvalid;

    logic                     w_idle;
    logic                     w_hi;
    logic                     w_wide_gnt;
    logic                     w_nar_gnt;
    logic                     w_we;
    logic [WADDR_WIDTH-1:0]   w_waddr;
    logic [WDATA_WIDTH-1:0]   w_wdata;
    logic [RADDR_WIDTH-1:0]   w_cur_idx;
    logic                     w_hazard;
    logic                     w_rd_gnt;

    // Write arbitration and write-port mux; everything is gated off in reset
    always_comb begin
        w_idle     = rst_n && (r_state == ST_IDLE);
        w_hi       = rst_n && (r_state == ST_WIDE_HI);
        w_wide_gnt = w_idle && wide_req_i && (!nar_req_i || r_rr_wide);
        w_nar_gnt  = w_idle && nar_req_i && (!wide_req_i || !r_rr_wide);
        w_we       = w_hi || w_wide_gnt || w_nar_gnt;
        w_waddr    = {WADDR_WIDTH{1'b0}};
        w_wdata    = {WDATA_WIDTH{1'b0}};
        if (w_hi) begin
            w_waddr = {r_hi_addr, 1'b1};
            w_wdata = r_hi_data;
        end else if (w_wide_gnt) begin
            w_waddr = {wide_addr_i, 1'b0};
            w_wdata = wide_wdata_i[WDATA_WIDTH-1:0];
        end else if (w_nar_gnt) begin
            w_waddr = nar_addr_i;
            w_wdata = nar_wdata_i;
        end else begin
            w_waddr = {WADDR_WIDTH{1'b0}};
            w_wdata = {WDATA_WIDTH{1'b0}};
        end
    end

    // Read hazard: this cycle's write, last cycle's write, or a pending high half
    always_comb begin
        w_cur_idx = w_waddr[WADDR_WIDTH-1:1];
        w_hazard  = (w_we && (w_cur_idx == rd_addr_i))
                 || (r_prev_vld && (r_prev_idx == rd_addr_i))
                 || ((r_state == ST_WIDE_HI) && (r_hi_addr == rd_addr_i));
        w_rd_gnt  = rst_n && rd_req_i && !w_hazard;
    end

    // FSM, round-robin pointer, hazard history and read-valid register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_wide  <= 1'b1;
            r_hi_addr  <= {RADDR_WIDTH{1'b0}};
            r_hi_data  <= {WDATA_WIDTH{1'b0}};
            r_prev_vld <= 1'b0;
            r_prev_idx <= {RADDR_WIDTH{1'b0}};
            r_rvalid   <= 1'b0;
        end else begin
            r_prev_vld <= w_we;
            r_prev_idx <= w_cur_idx;
            r_rvalid   <= w_rd_gnt;
            // Under contention the winner hands priority to the loser
            if (w_idle && wide_req_i && nar_req_i) begin
                r_rr_wide <= ~r_rr_wide;
            end else begin
                r_rr_wide <= r_rr_wide;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_wide_gnt) begin
                        r_state   <= ST_WIDE_HI;
                        r_hi_addr <= wide_addr_i;
                        r_hi_data <= wide_wdata_i[2*WDATA_WIDTH-1:WDATA_WIDTH];
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WIDE_HI: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign wide_gnt_o  = w_wide_gnt;
    assign nar_gnt_o   = w_nar_gnt;
    assign rf_we_o     = w_we;
    assign rf_waddr_o  = w_waddr;
    assign rf_wdata_o  = w_wdata;
    assign rd_gnt_o    = w_rd_gnt;
    assign rf_re_o     = w_rd_gnt;
    assign rf_raddr_o  = rd_addr_i;
    assign rd_rvalid_o = r_rvalid;
    assign rd_rdata_o  = rf_rdata_i;

endmodule

// File: tb/tb_scm_access_ctrl.sv
module tb_scm_access_ctrl;

    logic         clk;
    logic         rst_n;
    logic         wide_req_i;
    logic [3:0]   wide_addr_i;
    logic [127:0] wide_wdata_i;
    logic         wide_gnt_o;
    logic         nar_req_i;
    logic [4:0]   nar_addr_i;
    logic [63:0]  nar_wdata_i;
    logic         nar_gnt_o;
    logic         rd_req_i;
    logic [3:0]   rd_addr_i;
    logic         rd_gnt_o;
    logic         rd_rvalid_o;
    logic [127:0] rd_rdata_o;
    logic         rf_we_o;
    logic [4:0]   rf_waddr_o;
    logic [63:0]  rf_wdata_o;
    logic         rf_re_o;
    logic [3:0]   rf_raddr_o;
    logic [127:0] rf_rdata_i;

    int errors_r = 0;
    int checks_r = 0;

    localparam logic [63:0]  LO_C  = 64'h2222_2222_2222_2222;
    localparam logic [63:0]  HI_C  = 64'h1111_1111_1111_1111;
    localparam logic [127:0] RD_C  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    // expected per-cycle results of the contention run
    logic       exp_wgnt [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_ngnt [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0] exp_wa   [6] = '{5'd12, 5'd13, 5'd20, 5'd12, 5'd13, 5'd20};

    scm_access_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wide_req_i   (wide_req_i),
        .wide_addr_i  (wide_addr_i),
        .wide_wdata_i (wide_wdata_i),
        .wide_gnt_o   (wide_gnt_o),
        .nar_req_i    (nar_req_i),
        .nar_addr_i   (nar_addr_i),
        .nar_wdata_i  (nar_wdata_i),
        .nar_gnt_o    (nar_gnt_o),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_gnt_o     (rd_gnt_o),
        .rd_rvalid_o  (rd_rvalid_o),
        .rd_rdata_o   (rd_rdata_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_re_o      (rf_re_o),
        .rf_raddr_o   (rf_raddr_o),
        .rf_rdata_i   (rf_rdata_i)
    );

    // free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [127:0] act,
                             input logic [127:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // advance to just after the next rising edge (drive point)
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wide_req_i = 1'b0;
        nar_req_i  = 1'b0;
        rd_req_i   = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        wide_req_i   = 1'b0;
        wide_addr_i  = 4'd0;
        wide_wdata_i = 128'd0;
        nar_req_i    = 1'b0;
        nar_addr_i   = 5'd0;
        nar_wdata_i  = 64'd0;
        rd_req_i     = 1'b0;
        rd_addr_i    = 4'd0;
        rf_rdata_i   = RD_C;

        // --- reset: requests present but nothing granted ---
        next_cycle();
        nar_req_i = 1'b1; nar_addr_i = 5'd3; nar_wdata_i = 64'hA5;
        rd_req_i  = 1'b1; rd_addr_i = 4'd9;
        @(negedge clk);
        check_val("rst_nar_gnt", nar_gnt_o, 1'b0);
        check_val("rst_we", rf_we_o, 1'b0);
        check_val("rst_rd_gnt", rd_gnt_o, 1'b0);
        next_cycle();
        @(negedge clk);
        check_val("rst_rvalid", rd_rvalid_o, 1'b0);

        // --- first narrow write after release ---
        next_cycle();
        rst_n = 1'b1; rd_req_i = 1'b0;
        @(negedge clk);
        check_val("nar_gnt", nar_gnt_o, 1'b1);
        check_val("nar_we", rf_we_o, 1'b1);
        check_val("nar_waddr", rf_waddr_o, 5'd3);
        check_val("nar_wdata", rf_wdata_o, 64'hA5);
        check_val("nar_rvalid", rd_rvalid_o, 1'b0);

        // --- wide write split into two halves ---
        next_cycle();
        nar_req_i = 1'b0;
        wide_req_i = 1'b1; wide_addr_i = 4'd2; wide_wdata_i = {HI_C, LO_C};
        @(negedge clk);
        check_val("w_lo_gnt", wide_gnt_o, 1'b1);
        check_val("w_lo_waddr", rf_waddr_o, 5'd4);
        check_val("w_lo_wdata", rf_wdata_o, LO_C);
        next_cycle();
        wide_req_i = 1'b0;
        nar_req_i = 1'b1; nar_addr_i = 5'd9; nar_wdata_i = 64'h99;
        @(negedge clk);
        check_val("w_hi_wgnt", wide_gnt_o, 1'b0);
        check_val("w_hi_ngnt", nar_gnt_o, 1'b0);
        check_val("w_hi_we", rf_we_o, 1'b1);
        check_val("w_hi_waddr", rf_waddr_o, 5'd5);
        check_val("w_hi_wdata", rf_wdata_o, HI_C);
        next_cycle();
        @(negedge clk);
        check_val("w_idle_ngnt", nar_gnt_o, 1'b1);
        check_val("w_idle_waddr", rf_waddr_o, 5'd9);

        // --- contention after a fresh reset: wide, hi, narrow, ... ---
        next_cycle();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        wide_req_i = 1'b1; wide_addr_i = 4'd6; wide_wdata_i = {HI_C, LO_C};
        nar_req_i = 1'b1; nar_addr_i = 5'd20; nar_wdata_i = 64'h77;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("mix%0d_wgnt", i), wide_gnt_o, exp_wgnt[i]);
            check_val($sformatf("mix%0d_ngnt", i), nar_gnt_o, exp_ngnt[i]);
            check_val($sformatf("mix%0d_we", i), rf_we_o, 1'b1);
            check_val($sformatf("mix%0d_waddr", i), rf_waddr_o, exp_wa[i]);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // --- read stalled behind a wide write to the same index ---
        wide_req_i = 1'b1; wide_addr_i = 4'd7; wide_wdata_i = RD_C;
        rd_req_i = 1'b1; rd_addr_i = 4'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("haz_t%0d_gnt", i), rd_gnt_o, 1'b0);
            next_cycle();
            wide_req_i = 1'b0;
        end
        @(negedge clk);
        check_val("haz_t3_gnt", rd_gnt_o, 1'b1);
        check_val("haz_t3_re", rf_re_o, 1'b1);
        check_val("haz_t3_raddr", rf_raddr_o, 4'd7);
        check_val("haz_t3_rvalid", rd_rvalid_o, 1'b0);
        next_cycle();
        rd_req_i = 1'b0;
        @(negedge clk);
        check_val("haz_t4_rvalid", rd_rvalid_o, 1'b1);
        check_val("haz_t4_rdata", rd_rdata_o, RD_C);

        // --- read and narrow write to different indices together ---
        next_cycle();
        nar_req_i = 1'b1; nar_addr_i = 5'd0; nar_wdata_i = 64'h1;
        rd_req_i = 1'b1; rd_addr_i = 4'd1;
        @(negedge clk);
        check_val("par_ngnt", nar_gnt_o, 1'b1);
        check_val("par_rgnt", rd_gnt_o, 1'b1);
        check_val("par_re", rf_re_o, 1'b1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_val("par_rvalid", rd_rvalid_o, 1'b1);

        // --- reset while the high half is pending ---
        next_cycle();
        wide_req_i = 1'b1; wide_addr_i = 4'd3; wide_wdata_i = {HI_C, LO_C};
        @(negedge clk);
        check_val("rhi_gnt", wide_gnt_o, 1'b1);
        next_cycle();
        wide_req_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rhi_rst_we", rf_we_o, 1'b0);
        check_val("rhi_rst_wgnt", wide_gnt_o, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        nar_req_i = 1'b1; nar_addr_i = 5'd8; nar_wdata_i = 64'h88;
        @(negedge clk);
        check_val("rhi_ngnt", nar_gnt_o, 1'b1);
        check_val("rhi_waddr", rf_waddr_o, 5'd8);
        check_val("rhi_wdata", rf_wdata_o, 64'h88);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_val("rhi_no_hi", rf_we_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule

// File: doc/scm_access_ctrl.md
Name: scm_access_ctrl

Overview:
- Front-end controller for a latch-based 1W / N-read register file with a 64b write port and a 128b read port.
- Sits between two write requesters (one 128b wide, one 64b narrow) and one 128b reader.
- Serialises wide writes into two narrow writes and round-robin arbitrates the single write port.
- Stalls reads that would hit write data the latch array has not yet captured.

Parameters:
- WADDR_WIDTH, 5, narrow (64b) word address width
- WDATA_WIDTH, 64, write port / narrow word width
- RADDR_WIDTH, WADDR_WIDTH-1, wide (128b) word address width; wide index a covers narrow words 2a (low half) and 2a+1 (high half)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wide_req_i  in  1  wide write request
- wide_addr_i  in  RADDR_WIDTH  wide write address
- wide_wdata_i  in  2*WDATA_WIDTH  wide write data; bits [WDATA_WIDTH-1:0] form the low half
- wide_gnt_o  out  1  wide request accepted; address and data captured this cycle
- nar_req_i  in  1  narrow write request
- nar_addr_i  in  WADDR_WIDTH  narrow write address
- nar_wdata_i  in  WDATA_WIDTH  narrow write data
- nar_gnt_o  out  1  narrow request accepted
- rd_req_i  in  1  read request
- rd_addr_i  in  RADDR_WIDTH  wide read address
- rd_gnt_o  out  1  read accepted
- rd_rvalid_o  out  1  read data valid; registered, one cycle after rd_gnt_o
- rd_rdata_o  out  2*WDATA_WIDTH  read data; equals rf_rdata_i while rd_rvalid_o=1
- rf_we_o  out  1  register file WriteEnable
- rf_waddr_o  out  WADDR_WIDTH  register file WriteAddr
- rf_wdata_o  out  WDATA_WIDTH  register file WriteData
- rf_re_o  out  1  register file ReadEnable (equals rd_gnt_o)
- rf_raddr_o  out  RADDR_WIDTH  register file ReadAddr
- rf_rdata_i  in  2*WDATA_WIDTH  register file ReadData

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous active-low. On reset:
  - FSM enters IDLE.
  - RR pointer favours wide.
  - Hazard entries are invalidated.
  - rd_rvalid_o=0.
  - All grants and rf_we_o are 0 combinationally while rst_n=0.
- Reset mid-wide-write: the pending high half is discarded and never issued.
- FSM states:
  - IDLE
    - Wide only requesting: grant wide.
    - Narrow only requesting: grant narrow.
    - Both requesting: grant the pointer owner, then flip the pointer to the loser.
    - Narrow grant: rf_we_o=1, rf_waddr_o=nar_addr_i, rf_wdata_o=nar_wdata_i; stay in IDLE.
    - Wide grant: rf_we_o=1, rf_waddr_o={wide_addr_i,1'b0}, rf_wdata_o=low half; capture the high half and address; go to WIDE_HI.
  - WIDE_HI
    - rf_we_o=1, rf_waddr_o={addr,1'b1}, rf_wdata_o=captured high half.
    - No write grants in this state.
    - Return to IDLE.
- Throughput:
  - Narrow: one write per cycle.
  - Wide: one write per 2 cycles.
  - A wide/narrow mix contending continuously alternates wide, wide-hi, narrow, wide, ...
- Grant/request rules:
  - A grant is combinational from the request in the same cycle.
  - A requester holds address and data stable until granted.
  - rf_we_o is never asserted without a grant or a WIDE_HI cycle.
- Hazard tracking:
  - A write issued in cycle t (rf_we_o=1) is read-safe from cycle t+2 onward.
  - Hazard set = wide indices (rf_waddr_o>>1) of:
    - the write issued this cycle;
    - the write issued in the previous cycle;
    - a pending WIDE_HI high half.
  - rd_gnt_o = rd_req_i AND rd_addr_i not in the hazard set.
- Read path:
  - rf_raddr_o=rd_addr_i and rf_re_o=rd_gnt_o.
  - rd_rvalid_o is registered rd_gnt_o.
  - rd_rdata_o=rf_rdata_i (pass-through).
  - A read and a write to different wide indices proceed in the same cycle.
- Address wrap: no overflow logic; {addr,1'b1} of the maximum wide index is the top narrow word.

Test Plan:
- Reset, then narrow write addr 3 data 0xA5 → rf_we_o=1, rf_waddr_o=3, nar_gnt_o=1 in the same cycle; rd_rvalid_o=0 during reset.
- Wide write addr 2 data {0x11..,0x22..} → cycle t: waddr 4 / data 0x22..; cycle t+1: waddr 5 / data 0x11..; no grants at t+1; IDLE at t+2.
- Wide and narrow held high for 6 cycles after reset → grant order wide, (hi), narrow, wide, (hi), narrow; exactly one write per cycle.
- Wide write addr 7 at t, read addr 7 held from t → rd_gnt_o=0 at t, t+1, t+2; read granted at t+3; rd_rvalid_o at t+4 with the new 128b data.
- Narrow write addr 0 at t, read addr 1 at t → rd_gnt_o=1 at t; rf_re_o=1; rd_rvalid_o=1 at t+1.
- rst_n=0 during WIDE_HI → no write at the next cycle; FSM in IDLE; a following narrow write is granted immediately after release.
